fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end; successor to the single-cycle PC register, PC adder and instruction-memory path.
- Owns the fetch PC and talks to instruction memory over a variable-latency req/ack handshake.
- Buffers fetched instructions, each tagged with its PC, in a DEPTH-entry prefetch FIFO.
- Handles branch redirects with a flush and drop of any in-flight fetch, plus a level-sensitive halt.

Parameters:
- ADDR_W, 16, width of PC and memory address.
- INSTR_W, 16, instruction width.
- DEPTH, 4, prefetch FIFO entries; power of 2, at least 2.
- RESET_PC, 0, fetch PC after reset.
- PC_STEP, 2, PC increment per instruction.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  ADDR_W  fetch address; stable while imem_req is high.
- imem_ack  in  1  memory response valid; sampled only while imem_req is high.
- imem_rdata  in  INSTR_W  instruction data, valid with imem_ack.
- redirect_valid  in  1  one-cycle branch/jump redirect.
- redirect_addr  in  ADDR_W  redirect target.
- halt  in  1  level; stop issuing new fetches.
- inst_valid  out  1  FIFO head valid.
- inst_data  out  INSTR_W  FIFO head instruction.
- inst_pc  out  ADDR_W  PC of FIFO head.
- inst_ready  in  1  consumer accepts head when inst_valid && inst_ready.
- fetch_pc  out  ADDR_W  next address to be fetched.
- occupancy  out  $clog2(DEPTH)+1  FIFO entry count.
- idle  out  1  high in HALTED state with no request outstanding.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, fetch_pc=RESET_PC, FIFO empty, occupancy=0.
  - imem_req=0, inst_valid=0, idle=0.
  - imem_addr, inst_data, inst_pc read 0.
- State machine:
  - States: IDLE, FETCH, DROP, HALTED.
  - imem_req=1 in FETCH and DROP; imem_addr=fetch_pc.
  - Transitions are evaluated at each edge, in priority order:
    - IDLE: halt -> HALTED; else occupancy_next<DEPTH -> FETCH.
    - FETCH, no ack, redirect -> DROP.
    - FETCH, ack:
      - Push {fetch_pc, imem_rdata}; fetch_pc += PC_STEP, wrapping mod 2^ADDR_W.
      - redirect (same cycle) overrides: data discarded, flush, fetch_pc=redirect_addr, then IDLE/HALTED rules apply.
      - else halt -> HALTED.
      - else occupancy_next<DEPTH -> stay FETCH, so back-to-back fetches run at 1/cycle.
      - else IDLE.
    - DROP: req held, data discarded on ack; then -> IDLE, or HALTED if halt.
      - A further redirect in DROP only updates fetch_pc and flushes.
    - HALTED: !halt -> IDLE.
- Slot rule:
  - A request issues only when a free slot is guaranteed.
  - occupancy_next counts the same-cycle pop.
  - A push into a full FIFO never occurs; assertion required.
- FIFO:
  - inst_valid = occupancy!=0; head is registered.
  - A push at edge N is visible in cycle N+1, so ack-to-inst_valid latency is 1 cycle.
  - Push and pop in the same cycle leave occupancy unchanged, including when full.
- Redirect:
  - Flush sets occupancy=0 and inst_valid=0 the next cycle.
  - Redirect beats a same-cycle pop: the pop counts as accepted, then the flush applies.
  - fetch_pc=redirect_addr, including while HALTED.
  - The first post-redirect request addresses redirect_addr.
- Halt:
  - Blocks new requests only.
  - An outstanding request completes and its data is pushed (FETCH) or dropped (DROP).
  - The FIFO keeps draining during halt.
- Reset mid-transaction: outstanding request abandoned; memory must tolerate req dropping.
- Arithmetic: PC increment and all address math are ADDR_W-bit unsigned with silent wrap.

Test Plan:
- Reset:
  - Stimulus: assert rst mid-fetch.
  - Response: imem_req=0, occupancy=0, fetch_pc=0x0000 immediately.
  - After release: req with imem_addr=0x0000 on the next edge.
- Fill and stall:
  - Stimulus: immediate ack, inst_ready=0.
  - Response: addresses 0,2,4,6 fetched; occupancy=4; req low.
  - Then one pop -> req reissues at 0x0008.
- Steady stream:
  - Stimulus: inst_ready=1, ack every cycle.
  - Response: inst_pc sequence 0,2,4,… at 1/cycle; occupancy stays constant.
- Redirect with outstanding request:
  - Stimulus: req at 0x0006 unacked; redirect to 0x0100; ack arrives 3 cycles later.
  - Response: data dropped; FIFO empty; next req addresses 0x0100.
  - First delivered inst_pc=0x0100.
- Halt:
  - Stimulus: halt rises while req is outstanding.
  - Response: the ack is pushed; no new req; idle=1; FIFO drains.
  - Release halt: fetch resumes at the next sequential PC.
- Wrap:
  - Stimulus: redirect to 0xFFFE.
  - Response: fetches 0xFFFE then 0x0000.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack channel plus the
// valid/ready instruction stream handed to the decoder.
interface fetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    logic               inst_valid;
    logic [INSTR_W-1:0] inst_data;
    logic [ADDR_W-1:0]  inst_pc;
    logic               inst_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues req/ack fetches to
// instruction memory and buffers PC-tagged instructions in a prefetch FIFO.
module fetch_unit #(
    parameter int ADDR_W   = 16,
    parameter int INSTR_W  = 16,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0,
    parameter int PC_STEP  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    fetch_unit_if.master               bus,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_addr,
    input  logic                       halt,
    output logic [ADDR_W-1:0]          fetch_pc,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       idle
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DROP, S_HALTED} state_t;

    state_t             state;
    logic               req_q;
    logic               idle_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  addr_q;

    logic [ADDR_W-1:0]  pc_mem   [DEPTH];
    logic [INSTR_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   occ;

    logic               pop;
    logic               push;
    logic [CNT_W-1:0]   occ_next;
    logic [ADDR_W-1:0]  pc_next;
    logic               has_room;

    // NOTE: every always_comb output gets a value on every path first, so no latch is inferred.
    always_comb begin
        pop      = (occ != '0) && bus.inst_ready;
        push     = (state == S_FETCH) && bus.imem_ack && !redirect_valid;
        occ_next = occ;
        pc_next  = pc_q;
        if (redirect_valid) begin
            occ_next = '0;
            pc_next  = redirect_addr;
        end else begin
            occ_next = occ + CNT_W'(push) - CNT_W'(pop);
            if (push)
                pc_next = pc_q + ADDR_W'(PC_STEP);
        end
        has_room = occ_next < CNT_W'(DEPTH);
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            req_q  <= 1'b0;
            idle_q <= 1'b0;
            addr_q <= '0;
            pc_q   <= ADDR_W'(RESET_PC);
        end else begin
            pc_q <= pc_next;
            case (state)
                S_IDLE: begin
                    if (halt) begin
                        state  <= S_HALTED;
                        idle_q <= 1'b1;
                    end else if (has_room) begin
                        state  <= S_FETCH;
                        req_q  <= 1'b1;
                        addr_q <= pc_next;
                    end
                end
                S_FETCH: begin
                    // A redirect with the ack discards the data; occ_next is then 0 so has_room holds.
                    if (bus.imem_ack) begin
                        if (halt) begin
                            state  <= S_HALTED;
                            req_q  <= 1'b0;
                            idle_q <= 1'b1;
                        end else if (has_room) begin
                            addr_q <= pc_next;
                        end else begin
                            state <= S_IDLE;
                            req_q <= 1'b0;
                        end
                    end else if (redirect_valid) begin
                        state <= S_DROP;
                    end
                end
                S_DROP: begin
                    // Address stays on the abandoned fetch until memory acks it.
                    if (bus.imem_ack) begin
                        req_q <= 1'b0;
                        if (halt) begin
                            state  <= S_HALTED;
                            idle_q <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_HALTED: begin
                    if (!halt) begin
                        state  <= S_IDLE;
                        idle_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            occ <= occ_next;
        end
    end

    // NOTE: FIFO storage is not reset; empty entries are masked by inst_valid at the outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= pc_q;
            data_mem[wr_ptr] <= bus.imem_rdata;
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && occ == CNT_W'(DEPTH)));

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = (occ != '0);
    assign bus.inst_data  = (occ != '0) ? data_mem[rd_ptr] : '0;
    assign bus.inst_pc    = (occ != '0) ? pc_mem[rd_ptr] : '0;
    assign fetch_pc       = pc_q;
    assign occupancy      = occ;
    assign idle           = idle_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, fill/stall, streaming, redirects,
// halt and PC wrap, each scenario with hand-computed expectations.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        halt;
    logic [15:0] fetch_pc;
    logic [2:0]  occupancy;
    logic        idle;

    logic        auto_ack;
    logic [15:0] acked [$];
    int          tests = 0;
    int          fails = 0;

    fetch_unit_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .halt           (halt),
        .fetch_pc       (fetch_pc),
        .occupancy      (occupancy),
        .idle           (idle)
    );

    always #5 clk = ~clk;

    // Memory returns addr ^ 0xA5A5 so every instruction is traceable to its PC.
    task automatic tick();
        if (auto_ack) begin
            bus.imem_ack   = bus.imem_req;
            bus.imem_rdata = bus.imem_addr ^ 16'hA5A5;
        end
        if (bus.imem_ack && bus.imem_req)
            acked.push_back(bus.imem_addr);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        auto_ack = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        bus.inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr = '0;
        halt = 1'b0;
        acked.delete();
        #2;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        auto_ack = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        bus.inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr = '0;
        halt = 1'b0;
        #1;
        tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
        tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        tests++; if (fetch_pc !== 16'h0000) begin fails++; $display("FAIL reset_pc: got %h want 0000", fetch_pc); end
        tests++; if (bus.inst_valid !== 1'b0 || idle !== 1'b0) begin fails++; $display("FAIL reset_valid_idle: got %b%b want 00", bus.inst_valid, idle); end
        tests++; if (bus.imem_addr !== 16'h0 || bus.inst_data !== 16'h0 || bus.inst_pc !== 16'h0) begin
            fails++; $display("FAIL reset_zero_buses: got %h %h %h want 0", bus.imem_addr, bus.inst_data, bus.inst_pc); end
        tick(); tick();
        rst = 1'b0;
        tick();
        tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin
            fails++; $display("FAIL reset_first_req: got %b %h want 1 0000", bus.imem_req, bus.imem_addr); end
        auto_ack = 1'b1;
        tick(); tick();
        auto_ack = 1'b0;
        bus.imem_ack = 1'b0;
        tick();
        tests++; if (occupancy !== 3'd2 || fetch_pc !== 16'h0004 || bus.imem_req !== 1'b1) begin
            fails++; $display("FAIL reset_prefill: got occ %0d pc %h req %b want 2 0004 1", occupancy, fetch_pc, bus.imem_req); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (bus.imem_req !== 1'b0 || occupancy !== 3'd0 || fetch_pc !== 16'h0000) begin
            fails++; $display("FAIL reset_async: got req %b occ %0d pc %h want 0 0 0000", bus.imem_req, occupancy, fetch_pc); end
        rst = 1'b0;
        tick();
        tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin
            fails++; $display("FAIL reset_rerelease: got %b %h want 1 0000", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_fill_stall();
        do_reset();
        auto_ack = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        tests++; if (acked.size() != 4) begin fails++; $display("FAIL fill_count: got %0d want 4", acked.size()); end
        for (int i = 0; i < 4 && i < acked.size(); i++) begin
            tests++; if (acked[i] !== 16'(2 * i)) begin fails++; $display("FAIL fill_addr%0d: got %h want %h", i, acked[i], 16'(2 * i)); end
        end
        tests++; if (occupancy !== 3'd4 || bus.imem_req !== 1'b0) begin
            fails++; $display("FAIL fill_full: got occ %0d req %b want 4 0", occupancy, bus.imem_req); end
        tests++; if (bus.inst_pc !== 16'h0000 || bus.inst_data !== 16'hA5A5) begin
            fails++; $display("FAIL fill_head: got %h %h want 0000 a5a5", bus.inst_pc, bus.inst_data); end
        tick();
        tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL fill_stall: got req %b want 0", bus.imem_req); end
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0008 || occupancy !== 3'd3 || bus.inst_pc !== 16'h0002) begin
            fails++; $display("FAIL fill_reissue: got req %b addr %h occ %0d pc %h want 1 0008 3 0002",
                              bus.imem_req, bus.imem_addr, occupancy, bus.inst_pc); end
    endtask

    task automatic test_stream();
        do_reset();
        bus.inst_ready = 1'b1;
        auto_ack = 1'b1;
        tick(); tick();
        for (int k = 0; k < 6; k++) begin
            tests++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'(2 * k) || bus.inst_data !== (16'(2 * k) ^ 16'hA5A5) || occupancy !== 3'd1) begin
                fails++; $display("FAIL stream_%0d: got v %b pc %h data %h occ %0d want 1 %h %h 1", k,
                                  bus.inst_valid, bus.inst_pc, bus.inst_data, occupancy, 16'(2 * k), 16'(2 * k) ^ 16'hA5A5); end
            tick();
        end
    endtask

    task automatic test_redirect_ack_pop();
        do_reset();
        bus.inst_ready = 1'b1;
        auto_ack = 1'b1;
        tick(); tick(); tick();
        redirect_valid = 1'b1;
        redirect_addr = 16'h0200;
        tick();
        tests++; if (occupancy !== 3'd0 || bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0200 || fetch_pc !== 16'h0200) begin
            fails++; $display("FAIL redir_ack_flush: got occ %0d v %b req %b addr %h pc %h want 0 0 1 0200 0200",
                              occupancy, bus.inst_valid, bus.imem_req, bus.imem_addr, fetch_pc); end
        tick();
        tests++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0200) begin
            fails++; $display("FAIL redir_ack_first: got v %b pc %h want 1 0200", bus.inst_valid, bus.inst_pc); end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        auto_ack = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tests++; if (bus.imem_addr !== 16'h0006 || occupancy !== 3'd3) begin
            fails++; $display("FAIL drop_setup: got addr %h occ %0d want 0006 3", bus.imem_addr, occupancy); end
        auto_ack = 1'b0;
        bus.imem_ack = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr = 16'h0100;
        tick();
        tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0006 || occupancy !== 3'd0 || bus.inst_valid !== 1'b0 || fetch_pc !== 16'h0100) begin
            fails++; $display("FAIL drop_flush: got req %b addr %h occ %0d v %b pc %h want 1 0006 0 0 0100",
                              bus.imem_req, bus.imem_addr, occupancy, bus.inst_valid, fetch_pc); end
        tick(); tick();
        tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0006) begin
            fails++; $display("FAIL drop_hold: got req %b addr %h want 1 0006", bus.imem_req, bus.imem_addr); end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'hBEEF;
        tick();
        bus.imem_ack = 1'b0;
        tests++; if (bus.imem_req !== 1'b0 || occupancy !== 3'd0 || bus.inst_valid !== 1'b0) begin
            fails++; $display("FAIL drop_discard: got req %b occ %0d v %b want 0 0 0", bus.imem_req, occupancy, bus.inst_valid); end
        auto_ack = 1'b1;
        tick();
        tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0100) begin
            fails++; $display("FAIL drop_target_req: got req %b addr %h want 1 0100", bus.imem_req, bus.imem_addr); end
        tick();
        tests++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0100 || bus.inst_data !== 16'hA4A5) begin
            fails++; $display("FAIL drop_first_inst: got v %b pc %h data %h want 1 0100 a4a5", bus.inst_valid, bus.inst_pc, bus.inst_data); end
    endtask

    task automatic test_halt();
        do_reset();
        tick();
        halt = 1'b1;
        tick();
        tests++; if (bus.imem_req !== 1'b1 || idle !== 1'b0) begin
            fails++; $display("FAIL halt_outstanding: got req %b idle %b want 1 0", bus.imem_req, idle); end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'h1234;
        tick();
        bus.imem_ack = 1'b0;
        tests++; if (bus.imem_req !== 1'b0 || idle !== 1'b1 || occupancy !== 3'd1 || bus.inst_data !== 16'h1234 || fetch_pc !== 16'h0002) begin
            fails++; $display("FAIL halt_pushed: got req %b idle %b occ %0d data %h pc %h want 0 1 1 1234 0002",
                              bus.imem_req, idle, occupancy, bus.inst_data, fetch_pc); end
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        tests++; if (occupancy !== 3'd0 || bus.imem_req !== 1'b0 || idle !== 1'b1) begin
            fails++; $display("FAIL halt_drain: got occ %0d req %b idle %b want 0 0 1", occupancy, bus.imem_req, idle); end
        halt = 1'b0;
        tick(); tick();
        tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0002 || idle !== 1'b0) begin
            fails++; $display("FAIL halt_resume: got req %b addr %h idle %b want 1 0002 0", bus.imem_req, bus.imem_addr, idle); end
    endtask

    task automatic test_wrap();
        do_reset();
        halt = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_addr = 16'hFFFE;
        tick();
        tests++; if (fetch_pc !== 16'hFFFE || bus.imem_req !== 1'b0 || idle !== 1'b1) begin
            fails++; $display("FAIL wrap_halted_redirect: got pc %h req %b idle %b want fffe 0 1", fetch_pc, bus.imem_req, idle); end
        halt = 1'b0;
        auto_ack = 1'b1;
        tick(); tick();
        tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'hFFFE) begin
            fails++; $display("FAIL wrap_first: got req %b addr %h want 1 fffe", bus.imem_req, bus.imem_addr); end
        tick();
        tests++; if (bus.imem_addr !== 16'h0000 || fetch_pc !== 16'h0000) begin
            fails++; $display("FAIL wrap_second: got addr %h pc %h want 0000 0000", bus.imem_addr, fetch_pc); end
        tick();
        tests++; if (occupancy !== 3'd2 || bus.inst_pc !== 16'hFFFE || bus.inst_data !== 16'h5A5B) begin
            fails++; $display("FAIL wrap_head: got occ %0d pc %h data %h want 2 fffe 5a5b", occupancy, bus.inst_pc, bus.inst_data); end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within 50000 time units");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill_stall();
        test_stream();
        test_redirect_ack_pop();
        test_redirect_drop();
        test_halt();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
